// File: rtl/game_pkg.sv
// Shared definitions for the ball-game flow controller.
// State encodings and default timing constants.
package game_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int unsigned SERVE_DELAY_DEF = 50_000_000;
    localparam int unsigned OVER_HOLD_DEF   = 150_000_000;
    localparam int          CNT_W_DEF       = 28;

endpackage

// File: rtl/game_flow_if.sv
// Bundle of key inputs and engine-control outputs of the flow controller.
// master: key/engine side that drives keys; slave: controller view.
interface game_flow_if;

    logic       playKey;
    logic       menuKey;
    logic       gameOver;
    logic       engineEnable;
    logic       engineReset;
    logic [2:0] stateCode;

    modport master (
        output playKey, menuKey, gameOver,
        input  engineEnable, engineReset, stateCode
    );

    modport slave (
        input  playKey, menuKey, gameOver,
        output engineEnable, engineReset, stateCode
    );

endinterface

// File: rtl/game_flow_controller_key.sv
// key_press_detect: one-cycle press pulse from a debounced active-low key.
// Ports: clock, reset_n (sync, active-low), key (active-low), press.
module key_press_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic key,
    output logic press
);

    logic prev_q, prev_d;
    logic arm_q, arm_d;

    // arm blocks a press until the key has been seen released, so a key
    // held through reset does not fire when reset lifts.
    always_comb begin
        prev_d = key;
        arm_d  = arm_q | key;
        press  = prev_q & ~key & arm_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
            arm_q  <= key;
        end else begin
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Menu/Serve/Play/Pause/Over sequencer driving the engine enable and reset.
// Ports: clock, reset_n, playKey, menuKey, gameOver -> engineEnable,
// engineReset, stateCode. Macro GAME_FLOW_PAUSE_EN enables the PAUSE state.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEF,
    parameter int unsigned OVER_HOLD   = OVER_HOLD_DEF,
    parameter int          CNT_W       = CNT_W_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       playKey,
    input  logic       menuKey,
    input  logic       gameOver,
    output logic       engineEnable,
    output logic       engineReset,
    output logic [2:0] stateCode
);

    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0] OVER_LOAD  = CNT_W'(OVER_HOLD - 1);

    logic             play_press;
    logic             menu_press;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             rst_q, rst_d;
    logic             cnt_zero;

    key_press_detect u_play (
        .clock   (clock),
        .reset_n (reset_n),
        .key     (playKey),
        .press   (play_press)
    );

    key_press_detect u_menu (
        .clock   (clock),
        .reset_n (reset_n),
        .key     (menuKey),
        .press   (menu_press)
    );

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_MENU: begin
                if (!menu_press && play_press) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (menu_press)    state_d = ST_MENU;
                else if (cnt_zero) state_d = ST_PLAY;
                else               cnt_d   = cnt_q - 1'b1;
            end
            ST_PLAY: begin
                if (menu_press)      state_d = ST_MENU;
                else if (gameOver)   state_d = ST_OVER;
`ifdef GAME_FLOW_PAUSE_EN
                else if (play_press) state_d = ST_PAUSE;
`endif
            end
`ifdef GAME_FLOW_PAUSE_EN
            ST_PAUSE: begin
                if (menu_press)      state_d = ST_MENU;
                else if (play_press) state_d = ST_PLAY;
            end
`endif
            ST_OVER: begin
                if (menu_press)      state_d = ST_MENU;
                else if (play_press) state_d = ST_SERVE;
                else if (cnt_zero)   state_d = ST_MENU;
                else                 cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_MENU;
        endcase

        // Every entry restarts the shared counter from its full value.
        if (state_d == ST_SERVE && state_q != ST_SERVE) cnt_d = SERVE_LOAD;
        if (state_d == ST_OVER && state_q != ST_OVER)   cnt_d = OVER_LOAD;

        en_d  = (state_d == ST_PLAY);
        // A rematch pulses the engine reset for the first SERVE cycle.
        rst_d = (state_d == ST_MENU) ||
                (state_q == ST_OVER && state_d == ST_SERVE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_MENU;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rst_q   <= rst_d;
        end
    end

    assign engineEnable = en_q;
    assign engineReset  = rst_q;
    assign stateCode    = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller (SERVE_DELAY=3, OVER_HOLD=5).
// Expected {stateCode, engineEnable, engineReset} queued per driven cycle.
module tb_game_flow_controller;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    logic [4:0] exp_q[$];

    game_flow_if bus ();

    game_flow_controller #(
        .SERVE_DELAY (3),
        .OVER_HOLD   (5),
        .CNT_W       (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .playKey      (bus.playKey),
        .menuKey      (bus.menuKey),
        .gameOver     (bus.gameOver),
        .engineEnable (bus.engineEnable),
        .engineReset  (bus.engineReset),
        .stateCode    (bus.stateCode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [4:0] got,
                            input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got st=%0d en=%0b rst=%0b want st=%0d en=%0b rst=%0b",
                     tag, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs after the
    // edge, then pop and compare once the edge has produced them.
    task automatic step(input string tag, input logic pk, input logic mk,
                        input logic go, input logic [2:0] st,
                        input logic en, input logic rs);
        logic [4:0] got;
        logic [4:0] exp;
        @(negedge clock);
        bus.playKey  = pk;
        bus.menuKey  = mk;
        bus.gameOver = go;
        exp_q.push_back({st, en, rs});
        @(posedge clock);
        #1;
        got = {bus.stateCode, bus.engineEnable, bus.engineReset};
        exp = exp_q.pop_front();
        check_eq(tag, got, exp);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        bus.playKey  = 1'b0;
        bus.menuKey  = 1'b1;
        bus.gameOver = 1'b0;

        // Key held through reset and after release: no transition.
        for (int i = 0; i < 3; i++) step("rst", 0, 1, 0, 0, 0, 1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) step("held", 0, 1, 0, 0, 0, 1);

        // Play press from MENU, SERVE for exactly 3 cycles, then PLAY.
        step("idle", 1, 1, 0, 0, 0, 1);
        step("srv0", 0, 1, 0, 1, 0, 0);
        step("srv1", 0, 1, 0, 1, 0, 0);
        step("srv2", 0, 1, 0, 1, 0, 0);
        step("play", 0, 1, 0, 2, 1, 0);
        step("play_hold", 1, 1, 0, 2, 1, 0);

        // gameOver in PLAY, OVER held 5 cycles then MENU.
        step("over0", 1, 1, 1, 4, 0, 0);
        for (int i = 0; i < 4; i++) step("over_n", 1, 1, 0, 4, 0, 0);
        step("over_end", 1, 1, 0, 0, 0, 1);

        // Menu press during SERVE aborts to MENU.
        step("srv_a", 0, 1, 0, 1, 0, 0);
        step("srv_menu", 0, 0, 0, 0, 0, 1);
        step("menu_idle", 1, 1, 0, 0, 0, 1);

        // Back into PLAY.
        step("srv_b0", 0, 1, 0, 1, 0, 0);
        step("srv_b1", 0, 1, 0, 1, 0, 0);
        step("srv_b2", 0, 1, 0, 1, 0, 0);
        step("play_b", 0, 1, 0, 2, 1, 0);
        step("play_b_rel", 1, 1, 0, 2, 1, 0);

`ifdef GAME_FLOW_PAUSE_EN
        step("pause", 0, 1, 0, 3, 0, 0);
        step("pause_go0", 1, 1, 1, 3, 0, 0);
        step("pause_go1", 1, 1, 1, 3, 0, 0);
        step("resume", 0, 1, 1, 2, 1, 0);
        step("resume_go", 0, 1, 1, 4, 0, 0);
`else
        step("nopause", 0, 1, 0, 2, 1, 0);
        step("nopause_go", 1, 1, 1, 4, 0, 0);
`endif
        step("over_wait", 1, 1, 0, 4, 0, 0);

        // Rematch from OVER pulses engine reset on SERVE entry.
        step("rematch", 0, 1, 0, 1, 0, 1);
        step("rm_srv1", 0, 1, 0, 1, 0, 0);
        step("rm_srv2", 0, 1, 0, 1, 0, 0);
        step("rm_play", 0, 1, 0, 2, 1, 0);
        step("rm_rel", 1, 1, 0, 2, 1, 0);

        // Simultaneous menu and play presses in PLAY: menu wins.
        step("both", 0, 0, 0, 0, 0, 1);
        step("both_rel", 1, 1, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
